// File: rtl/dsc_op_sequencer_if.sv
// Request, response and core-control bundle for dsc_op_sequencer.
// The stats outputs exist only when DSC_SEQ_STATS_EN is defined.
interface dsc_op_sequencer_if #(
    parameter int DATA_WIDTH = 4,
    parameter int NUM_INPUTS = 2,
    parameter int WXIP1      = DATA_WIDTH * NUM_INPUTS + 1
);
    localparam int OPW = NUM_INPUTS * DATA_WIDTH;

    logic             req_valid;
    logic             req_ready;
    logic [OPW-1:0]   req_data;
    logic [WXIP1-1:0] req_budget;

    logic             core_rst;
    logic             core_en;
    logic [OPW-1:0]   core_bin_data_in;
    logic             core_op_finished;
    logic [WXIP1-1:0] core_bin_data_out;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WXIP1-1:0] rsp_data;
    logic [WXIP1-1:0] rsp_cycles;
    logic             rsp_truncated;

`ifdef DSC_SEQ_STATS_EN
    logic [31:0]      stat_ops;
    logic [31:0]      stat_trunc;
`endif

    modport slave (
        input  req_valid,
        input  req_data,
        input  req_budget,
        input  core_op_finished,
        input  core_bin_data_out,
        input  rsp_ready,
        output req_ready,
        output core_rst,
        output core_en,
        output core_bin_data_in,
        output rsp_valid,
        output rsp_data,
        output rsp_cycles,
        output rsp_truncated
`ifdef DSC_SEQ_STATS_EN
        ,
        output stat_ops,
        output stat_trunc
`endif
    );

    modport master (
        output req_valid,
        output req_data,
        output req_budget,
        output core_op_finished,
        output core_bin_data_out,
        output rsp_ready,
        input  req_ready,
        input  core_rst,
        input  core_en,
        input  core_bin_data_in,
        input  rsp_valid,
        input  rsp_data,
        input  rsp_cycles,
        input  rsp_truncated
`ifdef DSC_SEQ_STATS_EN
        ,
        input  stat_ops,
        input  stat_trunc
`endif
    );
endinterface

// File: rtl/dsc_op_sequencer.sv
// Sequences one DSC multiplier core: load, run under a cycle budget, settle, respond.
// Optional op/truncation statistics: define DSC_SEQ_STATS_EN.
module dsc_op_sequencer #(
    parameter int DATA_WIDTH = 4,
    parameter int NUM_INPUTS = 2,
    parameter int WXIP1      = DATA_WIDTH * NUM_INPUTS + 1
) (
    input logic               gclk,
    input logic               rst_n,
    dsc_op_sequencer_if.slave bus
);
    localparam int OPW = NUM_INPUTS * DATA_WIDTH;
    localparam logic [WXIP1-1:0] CNT_MAX = '1;
    localparam logic [WXIP1-1:0] CNT_ONE = WXIP1'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_SETTLE,
        S_RESP
    } state_e;

    state_e           state_q, state_d;
    logic [OPW-1:0]   opnd_q, opnd_d;
    logic [WXIP1-1:0] budget_q, budget_d;
    logic [WXIP1-1:0] cnt_q, cnt_d;
    logic [WXIP1-1:0] rsp_data_q, rsp_data_d;
    logic [WXIP1-1:0] rsp_cycles_q, rsp_cycles_d;
    logic             trunc_q, trunc_d;

    logic [WXIP1-1:0] cnt_inc;
    logic             budget_hit;
    logic             sat_hit;
    logic             run_done;

    always_ff @(posedge gclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            opnd_q       <= '0;
            budget_q     <= '0;
            cnt_q        <= '0;
            rsp_data_q   <= '0;
            rsp_cycles_q <= '0;
            trunc_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            opnd_q       <= opnd_d;
            budget_q     <= budget_d;
            cnt_q        <= cnt_d;
            rsp_data_q   <= rsp_data_d;
            rsp_cycles_q <= rsp_cycles_d;
            trunc_q      <= trunc_d;
        end
    end

    // Exit tests look at the count including the cycle now ending.
    always_comb begin
        cnt_inc    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
        budget_hit = (budget_q != '0) && (cnt_inc == budget_q);
        sat_hit    = (cnt_inc == CNT_MAX);
        run_done   = bus.core_op_finished || budget_hit || sat_hit;
    end

    always_comb begin
        state_d       = state_q;
        opnd_d        = opnd_q;
        budget_d      = budget_q;
        cnt_d         = cnt_q;
        rsp_data_d    = rsp_data_q;
        rsp_cycles_d  = rsp_cycles_q;
        trunc_d       = trunc_q;
        bus.req_ready = 1'b0;
        bus.core_rst  = 1'b0;
        bus.core_en   = 1'b0;
        bus.rsp_valid = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                bus.req_ready = 1'b1;
                bus.core_rst  = 1'b1;
                if (bus.req_valid) begin
                    opnd_d   = bus.req_data;
                    budget_d = bus.req_budget;
                    cnt_d    = '0;
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                bus.core_en = 1'b1;
                cnt_d       = cnt_inc;
                if (run_done) begin
                    trunc_d = !bus.core_op_finished;
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                rsp_data_d   = bus.core_bin_data_out;
                rsp_cycles_d = cnt_q;
                state_d      = S_RESP;
            end
            S_RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.core_bin_data_in = opnd_q;
    assign bus.rsp_data         = rsp_data_q;
    assign bus.rsp_cycles       = rsp_cycles_q;
    assign bus.rsp_truncated    = trunc_q;

`ifdef DSC_SEQ_STATS_EN
    localparam logic [31:0] STAT_MAX = '1;

    logic [31:0] stat_ops_q, stat_ops_d;
    logic [31:0] stat_trunc_q, stat_trunc_d;
    logic        rsp_fire;

    always_ff @(posedge gclk or negedge rst_n) begin
        if (!rst_n) begin
            stat_ops_q   <= '0;
            stat_trunc_q <= '0;
        end else begin
            stat_ops_q   <= stat_ops_d;
            stat_trunc_q <= stat_trunc_d;
        end
    end

    always_comb begin
        rsp_fire     = (state_q == S_RESP) && bus.rsp_ready;
        stat_ops_d   = stat_ops_q;
        stat_trunc_d = stat_trunc_q;
        if (rsp_fire) begin
            if (stat_ops_q != STAT_MAX) begin
                stat_ops_d = stat_ops_q + 32'd1;
            end
            if (trunc_q && (stat_trunc_q != STAT_MAX)) begin
                stat_trunc_d = stat_trunc_q + 32'd1;
            end
        end
    end

    assign bus.stat_ops   = stat_ops_q;
    assign bus.stat_trunc = stat_trunc_q;
`endif
endmodule

// File: tb/tb_dsc_op_sequencer.sv
// Directed bench for dsc_op_sequencer with a stub core and a stop-rule model.
// Checks stats too when DSC_SEQ_STATS_EN is defined.
module tb_dsc_op_sequencer;
    localparam int DW = 4;
    localparam int NI = 2;
    localparam int W  = 9;

    logic gclk  = 1'b0;
    logic rst_n = 1'b1;

    always #5 gclk = ~gclk;

    dsc_op_sequencer_if #(.DATA_WIDTH(DW), .NUM_INPUTS(NI), .WXIP1(W)) bus ();

    dsc_op_sequencer #(.DATA_WIDTH(DW), .NUM_INPUTS(NI), .WXIP1(W)) dut (
        .gclk (gclk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Stub core: finishes during its F-th enabled cycle (F=0 never finishes).
    int         fin_after   = 0;
    logic [8:0] core_result = 9'h00F;
    int         ecnt        = 0;

    always @(posedge gclk) begin
        if (bus.core_rst) ecnt <= 0;
        else if (bus.core_en) ecnt <= ecnt + 1;
    end

    assign bus.core_op_finished  = bus.core_en && (fin_after > 0) && (ecnt == fin_after - 1);
    assign bus.core_bin_data_out = core_result;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected response of the operation in flight.
    logic       exp_active = 1'b0;
    logic [7:0] exp_opnd   = '0;
    logic [8:0] exp_data   = '0;
    logic [8:0] exp_cyc    = '0;
    logic       exp_tr     = 1'b0;
    int         en_total   = 0;
    int         exp_ops    = 0;
    int         exp_trunc  = 0;

    always @(negedge gclk) begin
        if (bus.core_en) en_total <= en_total + 1;
    end

    always @(negedge gclk) begin
        if (rst_n) begin
            if (exp_active && bus.rsp_valid) begin
                chk("rsp_data", 32'(bus.rsp_data), 32'(exp_data));
                chk("rsp_cycles", 32'(bus.rsp_cycles), 32'(exp_cyc));
                chk("rsp_truncated", 32'(bus.rsp_truncated), 32'(exp_tr));
                chk("req_ready_in_resp", 32'(bus.req_ready), 32'd0);
            end
            if (!exp_active) begin
                chk("no_spurious_rsp", 32'(bus.rsp_valid), 32'd0);
            end
            if (exp_active && bus.core_en) begin
                chk("core_bin_data_in", 32'(bus.core_bin_data_in), 32'(exp_opnd));
            end
        end
    end

    task automatic run_op(
        input  logic [7:0] data,
        input  logic [8:0] budget,
        input  int         fin,
        input  logic [8:0] result,
        input  int         hold,
        input  bit         inject,
        output int         lat,
        output logic [8:0] cyc,
        output logic       tr,
        output logic [8:0] dat
    );
        int n;
        int en_base;
        n  = 511;
        tr = 1'b1;
        if (budget != 0 && int'(budget) < n) n = int'(budget);
        if (fin > 0 && fin <= n) begin
            n  = fin;
            tr = 1'b0;
        end
        fin_after   = fin;
        core_result = result;
        exp_opnd    = data;
        exp_data    = result;
        exp_cyc     = 9'(n);
        exp_tr      = tr;
        exp_active  = 1'b1;
        en_base     = en_total;
        chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
        bus.req_data   = data;
        bus.req_budget = budget;
        bus.req_valid  = 1'b1;
        bus.rsp_ready  = 1'b0;
        @(posedge gclk);
        #1;
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.rsp_valid && lat < 700) begin
            @(posedge gclk);
            #1;
            lat++;
        end
        chk("latency", 32'(lat), 32'(n + 3));
        cyc = bus.rsp_cycles;
        tr  = bus.rsp_truncated;
        dat = bus.rsp_data;
        for (int i = 0; i < hold; i++) begin
            if (inject) begin
                bus.req_valid = 1'b1;
                bus.req_data  = 8'hFF;
            end
            @(posedge gclk);
            #1;
            chk("hold_req_ready", 32'(bus.req_ready), 32'd0);
            chk("hold_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("hold_operands", 32'(bus.core_bin_data_in), 32'(data));
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge gclk);
        #1;
        bus.rsp_ready = 1'b0;
        exp_active    = 1'b0;
        exp_ops++;
        if (exp_tr) exp_trunc++;
        chk("rsp_valid_after_hs", 32'(bus.rsp_valid), 32'd0);
        chk("req_ready_after_hs", 32'(bus.req_ready), 32'd1);
        chk("core_rst_after_hs", 32'(bus.core_rst), 32'd1);
        chk("en_cycles", 32'(en_total - en_base), 32'(n));
`ifdef DSC_SEQ_STATS_EN
        chk("stat_ops", bus.stat_ops, 32'(exp_ops));
        chk("stat_trunc", bus.stat_trunc, 32'(exp_trunc));
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int         lat;
        logic [8:0] cyc;
        logic       tr;
        logic [8:0] dat;

        bus.req_valid  = 1'b0;
        bus.req_data   = '0;
        bus.req_budget = '0;
        bus.rsp_ready  = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_core_rst", 32'(bus.core_rst), 32'd1);
        chk("rst_core_en", 32'(bus.core_en), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
        chk("rst_rsp_cycles", 32'(bus.rsp_cycles), 32'd0);
        chk("rst_rsp_truncated", 32'(bus.rsp_truncated), 32'd0);
        chk("rst_operands", 32'(bus.core_bin_data_in), 32'd0);
`ifdef DSC_SEQ_STATS_EN
        chk("rst_stat_ops", bus.stat_ops, 32'd0);
        chk("rst_stat_trunc", bus.stat_trunc, 32'd0);
`endif
        repeat (3) @(posedge gclk);
        #1;
        rst_n = 1'b1;
        @(posedge gclk);
        #1;

        run_op(8'h53, 9'd0, 20, 9'h00F, 0, 1'b0, lat, cyc, tr, dat);
        chk("t1_latency", 32'(lat), 32'd23);
        chk("t1_cycles", 32'(cyc), 32'd20);
        chk("t1_trunc", 32'(tr), 32'd0);
        chk("t1_data", 32'(dat), 32'h00F);
        chk("t1_operands", 32'(bus.core_bin_data_in), 32'h53);

        run_op(8'h53, 9'd8, 20, 9'h00F, 0, 1'b0, lat, cyc, tr, dat);
        chk("t2_cycles", 32'(cyc), 32'd8);
        chk("t2_trunc", 32'(tr), 32'd1);

        run_op(8'h53, 9'd20, 20, 9'h00F, 0, 1'b0, lat, cyc, tr, dat);
        chk("t3_cycles", 32'(cyc), 32'd20);
        chk("t3_trunc", 32'(tr), 32'd0);

        run_op(8'h21, 9'd0, 0, 9'h00F, 0, 1'b0, lat, cyc, tr, dat);
        chk("t4_cycles", 32'(cyc), 32'd511);
        chk("t4_trunc", 32'(tr), 32'd1);
        chk("t4_latency", 32'(lat), 32'd514);

        run_op(8'h9C, 9'd1, 20, 9'h00F, 0, 1'b0, lat, cyc, tr, dat);
        chk("t5_cycles", 32'(cyc), 32'd1);
        chk("t5_trunc", 32'(tr), 32'd1);

        run_op(8'hA7, 9'd5, 3, 9'h1A5, 10, 1'b1, lat, cyc, tr, dat);
        chk("t6_cycles", 32'(cyc), 32'd3);
        chk("t6_trunc", 32'(tr), 32'd0);
        chk("t6_data", 32'(dat), 32'h1A5);

        run_op(8'h3E, 9'd0, 1, 9'h0C3, 0, 1'b0, lat, cyc, tr, dat);
        chk("t7_cycles", 32'(cyc), 32'd1);
        chk("t7_trunc", 32'(tr), 32'd0);

        run_op(8'h6B, 9'd300, 0, 9'h00F, 0, 1'b0, lat, cyc, tr, dat);
        chk("t8_cycles", 32'(cyc), 32'd300);
        chk("t8_trunc", 32'(tr), 32'd1);

        // Abort mid-RUN; no response may follow.
        fin_after      = 0;
        bus.req_data   = 8'h77;
        bus.req_budget = 9'd0;
        bus.req_valid  = 1'b1;
        @(posedge gclk);
        #1;
        bus.req_valid = 1'b0;
        repeat (10) @(posedge gclk);
        #1;
        chk("abort_running", 32'(bus.core_en), 32'd1);
`ifdef DSC_SEQ_STATS_EN
        chk("abort_stat_ops_pre", bus.stat_ops, 32'(exp_ops));
        chk("abort_stat_trunc_pre", bus.stat_trunc, 32'(exp_trunc));
`endif
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_core_rst", 32'(bus.core_rst), 32'd1);
        chk("abort_core_en", 32'(bus.core_en), 32'd0);
        chk("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("abort_req_ready", 32'(bus.req_ready), 32'd1);
`ifdef DSC_SEQ_STATS_EN
        chk("abort_stat_ops", bus.stat_ops, 32'd0);
        chk("abort_stat_trunc", bus.stat_trunc, 32'd0);
`endif
        exp_ops   = 0;
        exp_trunc = 0;
        @(posedge gclk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(posedge gclk);
        #1;
        chk("post_abort_idle_en", 32'(bus.core_en), 32'd0);
        chk("post_abort_idle_rdy", 32'(bus.req_ready), 32'd1);

        run_op(8'h12, 9'd4, 0, 9'h055, 0, 1'b0, lat, cyc, tr, dat);
        chk("t9_cycles", 32'(cyc), 32'd4);
        chk("t9_trunc", 32'(tr), 32'd1);
        chk("t9_data", 32'(dat), 32'h055);

        repeat (3) @(posedge gclk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
